// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatcher: issue-channel classes, opcode tables
// and the opcode classifier used on the IFQ head.
package dispatch_pkg;

    typedef enum logic [1:0] {
        CLS_INT = 2'd0,
        CLS_FP  = 2'd1,
        CLS_MEM = 2'd2
    } cls_e;

    typedef struct packed {
        cls_e cls;
        logic illegal;
    } class_t;

    localparam logic [6:0] OP_FP_OP    = 7'b1010011;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Unknown opcodes still go out on INT so ordering is preserved; only the flag marks them.
    function automatic class_t classify(input logic [6:0] opcode);
        class_t r;
        r.cls     = CLS_INT;
        r.illegal = 1'b0;
        case (opcode)
            OP_FP_OP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:
                r.cls = CLS_FP;
            OP_LOAD, OP_STORE, OP_LOAD_FP, OP_STORE_FP:
                r.cls = CLS_MEM;
            OP_OP, OP_OP_IMM, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_MISC_MEM, OP_SYSTEM:
                r.cls = CLS_INT;
            default:
                r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] cls_onehot(input cls_e cls);
        logic [2:0] v;
        v = 3'b001;
        case (cls)
            CLS_FP:  v = 3'b010;
            CLS_MEM: v = 3'b100;
            default: v = 3'b001;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dispatch_ifq.sv
// Instruction fetch queue: synchronous FIFO with flush; full/empty come from
// the occupancy count so pointers can wrap freely.
module dispatch_ifq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// Front-end dispatcher: buffers fetched instructions in the IFQ and hands the
// head, in program order and tagged, to the INT/FP/MEM issue channels.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned IFQ_DEPTH   = 8,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_instr,
    output logic [2:0]                   out_valid,
    input  logic [2:0]                   out_ready,
    output logic [XLEN-1:0]              out_instr,
    output logic [TAG_W-1:0]             out_tag,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic                         out_illegal,
    output logic [$clog2(IFQ_DEPTH):0]   ifq_count,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    logic [XLEN-1:0]  head_instr;
    logic             ifq_full;
    logic             ifq_empty;
    logic             sel_ready;
    logic             stage_free;
    logic             pop;
    logic             stall;
    class_t           head_cls;
    logic [TAG_W-1:0] tag_cnt;

    assign in_ready   = ~ifq_full;
    // out_valid is one-hot, so masking with out_ready ignores the idle channels.
    assign sel_ready  = |(out_valid & out_ready);
    assign stage_free = ~(|out_valid) | sel_ready;
    assign pop        = stage_free & ~ifq_empty;
    assign stall      = (|out_valid) & ~sel_ready;
    assign head_cls   = classify(head_instr[6:0]);

    dispatch_ifq #(
        .WIDTH (XLEN),
        .DEPTH (IFQ_DEPTH)
    ) u_ifq (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .wr_en   (in_valid & in_ready),
        .wr_data (in_instr),
        .rd_en   (pop),
        .rd_data (head_instr),
        .count   (ifq_count),
        .full    (ifq_full),
        .empty   (ifq_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid   <= '0;
            out_instr   <= '0;
            out_tag     <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_illegal <= 1'b0;
            tag_cnt     <= '0;
            stall_count <= '0;
        end else begin
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
            if (flush) begin
                out_valid <= '0;
            end else if (pop) begin
                out_valid   <= cls_onehot(head_cls.cls);
                out_instr   <= head_instr;
                out_tag     <= tag_cnt;
                out_rd      <= head_instr[11:7];
                out_rs1     <= head_instr[19:15];
                out_rs2     <= head_instr[24:20];
                out_illegal <= head_cls.illegal;
                tag_cnt     <= tag_cnt + TAG_W'(1);
            end else if (stage_free) begin
                out_valid <= '0;
            end
        end
    end

endmodule
